eeprom_rd_buffer: RTL and testbench

EEPROM_RD_BUFFER -- requirements
Module: eeprom_rd_buffer

---
 rtl/eeprom_rd_buffer.sv | 93 +++++++++
 tb/tb_eeprom_rd_buffer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/eeprom_rd_buffer.sv
// Buffers bytes read from EEPROM in a small FIFO. It presents them one at a time on
// show_data, paced by a fixed display interval, with a one-cycle show_valid strobe.
module eeprom_rd_buffer #(
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] CNT_SHOW_MAX = 32'd49_999_999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_en,
  input  logic       i2c_end,
  input  logic [7:0] rd_data,
  input  logic       clr,
  output logic [7:0] show_data,
  output logic       show_valid,
  output logic [4:0] fifo_cnt,
  output logic       full,
  output logic       empty,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   cnt_show;
  logic          rd_req, push, drop, pop, cnt_done;

  assign full     = (fifo_cnt == 5'(FIFO_DEPTH));
  assign empty    = (fifo_cnt == 5'd0);
  assign rd_req   = i2c_end && rd_en && !clr;
  assign push     = rd_req && !full;
  assign drop     = rd_req && full;
  assign cnt_done = (cnt_show == CNT_SHOW_MAX);

  // NOTE: always_comb assigns every output a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    if (!clr) begin
      case (state)
        IDLE: if (!empty) begin
          pop       = 1'b1;
          state_nxt = HOLD;
        end
        HOLD: if (cnt_done) begin
          if (!empty) pop = 1'b1;
          else        state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; fifo_cnt gating keeps stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rd_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= 5'd0;
      overflow   <= 1'b0;
      cnt_show   <= 32'd0;
      show_data  <= 8'h00;
      show_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      show_valid <= pop;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (drop) overflow <= 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        show_data <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 5'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 5'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      // The interval counter only runs in HOLD and rolls over when the interval expires.
      if (state == HOLD && !cnt_done) cnt_show <= cnt_show + 32'd1;
      else                            cnt_show <= 32'd0;
    end
  end

endmodule

// File: tb/tb_eeprom_rd_buffer.sv
// Self-checking bench for eeprom_rd_buffer: directed scenarios plus random traffic,
// compared against a timestamp-based queue model of the display pacing.
module tb_eeprom_rd_buffer;

  localparam int DEPTH  = 8;
  localparam int PERIOD = 10;  // CNT_SHOW_MAX + 1

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rd_en = 1'b0;
  logic       i2c_end = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic       clr = 1'b0;
  logic [7:0] show_data;
  logic       show_valid;
  logic [4:0] fifo_cnt;
  logic       full, empty, overflow;

  int checks = 0;
  int errors = 0;

  eeprom_rd_buffer #(.FIFO_DEPTH(DEPTH), .CNT_SHOW_MAX(32'd9)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .i2c_end(i2c_end), .rd_data(rd_data),
    .clr(clr), .show_data(show_data), .show_valid(show_valid), .fifo_cnt(fifo_cnt),
    .full(full), .empty(empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus the edge index of the last pop. A pop is due when
  // the display is idle, or exactly PERIOD edges after the previous pop.
  logic [7:0] q[$];
  bit         m_ok = 0;
  bit         m_idle = 1;
  int         cyc = 0;
  int         last_pop = 0;
  logic [7:0] m_show = 8'h00;
  bit         m_valid = 0;
  bit         m_ovf = 0;

  always @(posedge clk) begin
    bit was_full, do_pop;
    cyc++;
    if (rst || clr) begin
      q.delete();
      m_idle  = 1;
      m_show  = 8'h00;
      m_valid = 0;
      m_ovf   = 0;
      if (rst) m_ok = 1;
    end else begin
      was_full = (q.size() == DEPTH);
      do_pop   = (q.size() > 0) && (m_idle || (cyc - last_pop == PERIOD));
      if (!m_idle && (cyc - last_pop == PERIOD) && q.size() == 0) m_idle = 1;
      m_valid = 0;
      if (do_pop) begin
        m_show   = q.pop_front();
        m_valid  = 1;
        last_pop = cyc;
        m_idle   = 0;
      end
      if (i2c_end && rd_en) begin
        if (was_full) m_ovf = 1;
        else          q.push_back(rd_data);
      end
    end
  end

  // Record every observed strobe with its edge index for the directed checks.
  logic [7:0] shown[$];
  int         shown_cyc[$];

  always @(negedge clk) begin
    if (m_ok) begin
      check("show_data",  {24'd0, show_data}, {24'd0, m_show});
      check("show_valid", {31'd0, show_valid}, {31'd0, m_valid});
      check("fifo_cnt",   {27'd0, fifo_cnt},   q.size());
      check("full",       {31'd0, full},       {31'd0, q.size() == DEPTH});
      check("empty",      {31'd0, empty},      {31'd0, q.size() == 0});
      check("overflow",   {31'd0, overflow},   {31'd0, m_ovf});
      if (show_valid === 1'b1) begin
        shown.push_back(show_data);
        shown_cyc.push_back(cyc);
      end
    end
  end

  // Inputs launch 1 time unit after a rising edge and are sampled at the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_byte(input logic [7:0] d);
    i2c_end = 1'b1; rd_en = 1'b1; rd_data = d;
    tick();
    i2c_end = 1'b0; rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    wait_n(3);
    rst = 1'b0;
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_cnt", {27'd0, fifo_cnt}, 32'd0);
    check("rst_show", {24'd0, show_data}, 32'd0);

    // Single byte: launched at edge N, shown at edge N+2.
    push_byte(8'hA5);
    check("a5_cnt1", {27'd0, fifo_cnt}, 32'd1);
    check("a5_no_valid_yet", {31'd0, show_valid}, 32'd0);
    tick();
    check("a5_valid", {31'd0, show_valid}, 32'd1);
    check("a5_data", {24'd0, show_data}, 32'hA5);
    check("a5_empty", {31'd0, empty}, 32'd1);
    tick();
    check("a5_pulse_len", {31'd0, show_valid}, 32'd0);
    wait_n(15);

    // Three back-to-back bytes shown PERIOD cycles apart.
    shown.delete(); shown_cyc.delete();
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33);
    wait_n(40);
    check("seq_count", shown.size(), 32'd3);
    if (shown.size() == 3) begin
      check("seq_b0", {24'd0, shown[0]}, 32'h11);
      check("seq_b1", {24'd0, shown[1]}, 32'h22);
      check("seq_b2", {24'd0, shown[2]}, 32'h33);
      check("seq_gap0", shown_cyc[1] - shown_cyc[0], PERIOD);
      check("seq_gap1", shown_cyc[2] - shown_cyc[1], PERIOD);
    end

    // Overfill while the display is held: the ninth byte is dropped.
    shown.delete(); shown_cyc.delete();
    push_byte(8'h55);
    for (int i = 0; i < 9; i++) push_byte(8'(i));
    check("of_full", {31'd0, full}, 32'd1);
    check("of_overflow", {31'd0, overflow}, 32'd1);
    check("of_cnt", {27'd0, fifo_cnt}, 32'd8);
    wait_n(DEPTH * PERIOD + 15);
    check("of_count", shown.size(), 32'd9);
    if (shown.size() == 9) begin
      check("of_first", {24'd0, shown[0]}, 32'h55);
      for (int i = 0; i < 8; i++) check("of_order", {24'd0, shown[i+1]}, i);
    end
    push_byte(8'h5A);
    wait_n(3);
    check("wrap_byte", {24'd0, show_data}, 32'h5A);
    check("of_sticky", {31'd0, overflow}, 32'd1);
    wait_n(15);

    // Write-transfer pulses are ignored.
    pulse_clr();
    shown.delete();
    for (int i = 0; i < 3; i++) begin
      i2c_end = 1'b1; rd_en = 1'b0; rd_data = 8'hFF;
      tick();
      i2c_end = 1'b0;
      tick();
    end
    check("wr_cnt", {27'd0, fifo_cnt}, 32'd0);
    wait_n(5);
    check("wr_no_show", shown.size(), 32'd0);

    // clr in HOLD with three entries, colliding with a read pulse.
    push_byte(8'h01); wait_n(2);
    push_byte(8'h02); push_byte(8'h03); push_byte(8'h04);
    check("clr_pre_cnt", {27'd0, fifo_cnt}, 32'd3);
    clr = 1'b1; i2c_end = 1'b1; rd_en = 1'b1; rd_data = 8'h99;
    tick();
    clr = 1'b0; i2c_end = 1'b0; rd_en = 1'b0;
    check("clr_cnt", {27'd0, fifo_cnt}, 32'd0);
    check("clr_ovf", {31'd0, overflow}, 32'd0);
    check("clr_show", {24'd0, show_data}, 32'd0);
    check("clr_empty", {31'd0, empty}, 32'd1);
    shown.delete();
    wait_n(25);
    check("clr_no_show", shown.size(), 32'd0);

    // Reset pulse mid-HOLD with four entries.
    push_byte(8'h10); wait_n(2);
    for (int i = 0; i < 4; i++) push_byte(8'h11 + 8'(i));
    check("rst_pre_cnt", {27'd0, fifo_cnt}, 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_cnt", {27'd0, fifo_cnt}, 32'd0);
    check("rst2_show", {24'd0, show_data}, 32'd0);
    check("rst2_valid", {31'd0, show_valid}, 32'd0);
    shown.delete();
    wait_n(25);
    check("rst2_no_show", shown.size(), 32'd0);
    push_byte(8'h77);
    tick();
    check("rst2_new_byte", {24'd0, show_data}, 32'h77);

    // Random traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      i2c_end = ($urandom_range(0, 5) == 0);
      rd_en   = ($urandom_range(0, 4) != 0);
      rd_data = 8'($urandom);
      clr     = ($urandom_range(0, 299) == 0);
      rst     = ($urandom_range(0, 599) == 0);
      tick();
    end
    i2c_end = 1'b0; rd_en = 1'b0; clr = 1'b0; rst = 1'b0;
    wait_n(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
